arith_count_unit: RTL and testbench
===================================

Name: arith_count_unit

Overview:
- Parametrised successor to the team's single-bit adder and decade-counter block.
- Provides three functions behind one registered, op-selected datapath:
  - WIDTH-bit add with carry-in;
  - WIDTH-bit subtract with borrow-in, plus carry/borrow and signed-overflow flags;
  - modulo-CNT_MOD up/down counter with load, clear and terminal-count pulse.
- The counter is paced by an internal prescaler tick.
- Sits between switch/pushbutton input logic and display/LED drivers in lab-board designs.

Parameters:
- WIDTH, 4: operand and result width, must be >= 1.
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- TICK_HZ, 1: counter step rate in Hz; TICK_DIV = CLK_FREQ/TICK_HZ, must be >= 1.
- CNT_MOD, 10: counter modulus, must be >= 2; CW = $clog2(CNT_MOD).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset. One clock; reset is asynchronous and active-high.
- op, input, 3: 000 ADD, 001 SUB, 010 CNT_UP, 011 CNT_DN, 100 LOAD, 101 CLEAR, 110 PAUSE, 111 reserved.
- in_valid, input, 1: qualifies a/b/cin for ADD/SUB/LOAD/CLEAR.
- a, input, WIDTH: operand A; also the LOAD value.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in for ADD, borrow-in for SUB.
- sum, output, WIDTH: registered arithmetic result.
- carry, output, 1: ADD carry-out / SUB borrow-out.
- ovf, output, 1: signed (two's-complement) overflow.
- out_valid, output, 1: one-cycle pulse when sum/carry/ovf are updated.
- count, output, CW: counter value, always in 0..CNT_MOD-1.
- tc, output, 1: one-cycle pulse on counter wrap.

Behaviour:
- Reset (async, rst=1): sum=0, carry=0, ovf=0, out_valid=0, count=0, tc=0, prescaler count=0, tick=0.
- ADD (op=000 & in_valid): at the next edge:
  - {carry,sum} <= a + b + cin, computed at WIDTH+1 bits;
  - ovf <= (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]);
  - out_valid <= 1.
  - Latency is 1 cycle.
- SUB (op=001 & in_valid):
  - sum <= a - b - cin, modulo 2^WIDTH;
  - carry <= 1 iff a < b + cin (unsigned borrow);
  - ovf <= (a[MSB]!=b[MSB]) && (sum[MSB]!=a[MSB]);
  - out_valid <= 1.
- Holding rule: out_valid=0 on every cycle without an accepted ADD/SUB. sum/carry/ovf hold their last value in all other ops and when in_valid=0; they are never cleared except by reset.
- Prescaler: counts 0..TICK_DIV-1 only while op is 010 or 011. In any other op it is forced to 0 on each edge. tick is a 1-cycle pulse when the prescaler wraps. The first tick arrives TICK_DIV cycles after entering a count op. With TICK_DIV=1, tick is high every cycle in count ops.
- CNT_UP on tick:
  - if count==CNT_MOD-1: count <= 0 and tc <= 1;
  - else count <= count+1.
- CNT_DN on tick:
  - if count==0: count <= CNT_MOD-1 and tc <= 1;
  - else count <= count-1.
- Switching 010<->011 directly keeps the prescaler running, without a restart.
- LOAD (op=100 & in_valid): count <= a if a < CNT_MOD, else CNT_MOD-1 (saturate). Compare at full width; a wider than CW is legal. tc stays 0.
- CLEAR (op=101 & in_valid): count <= 0; tc stays 0.
- PAUSE (op=110): count holds and the prescaler is cleared.
- Reserved (op=111): no state change.
- tc is 0 on every cycle other than a wrap cycle.
- Count ops ignore in_valid.
- Reset asserted mid-count or mid-operation returns all state to reset values immediately. Counting resumes from 0 with a full TICK_DIV delay after rst deasserts.

Decomposition:
- Package arith_count_pkg:
  - op_e enum (3-bit: OP_ADD, OP_SUB, OP_CNT_UP, OP_CNT_DN, OP_LOAD, OP_CLEAR, OP_PAUSE, OP_RSVD);
  - localparam helper function for TICK_DIV.
- One sub-module: tick_gen, with parameter DIV, ports clk, rst, en, tick. It implements the prescaler with a clear-when-disabled rule.
- The arithmetic stays in the top module as combinational functions feeding the result registers.

Test Plan (WIDTH=4, CNT_MOD=10, CLK_FREQ=4, TICK_HZ=1 so TICK_DIV=4):
- ADD a=7,b=9,cin=1, in_valid one cycle -> next cycle sum=1, carry=1, ovf=0, out_valid=1 for exactly one cycle. Then a=7,b=1,cin=0 -> sum=8, carry=0, ovf=1.
- SUB a=3,b=5,cin=0 -> sum=14, carry=1, ovf=0. Then a=8,b=1,cin=0 -> sum=7, carry=0, ovf=1. With in_valid=0 afterwards, sum/carry/ovf hold and out_valid=0.
- CNT_UP from count=0 for 40 cycles -> count steps every 4 cycles 1..9 then 0. tc pulses exactly once, on the 9->0 edge.
- LOAD a=12 -> count=9. Then CNT_DN -> 8 after 4 cycles. LOAD a=0 then CNT_DN -> 9 after 4 cycles with a tc pulse.
- CNT_UP 6 cycles, PAUSE 5 cycles, CNT_UP -> count frozen during PAUSE. Next increment occurs 4 cycles after resuming, not earlier.
- Assert rst asynchronously between clock edges at count=5 with prescaler mid-way -> all outputs 0 immediately. After release with CNT_UP, first increment occurs 4 cycles later.

Source files
------------

// File: rtl/arith_count_pkg.sv
// Shared types and elaboration helpers for the arithmetic/counter unit.
package arith_count_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_CNT_UP = 3'b010,
        OP_CNT_DN = 3'b011,
        OP_LOAD   = 3'b100,
        OP_CLEAR  = 3'b101,
        OP_PAUSE  = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    // Clock cycles per counter step.
    function automatic int tick_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

endpackage

// File: rtl/arith_count_unit_if.sv
// Operation request and result bundle between input logic and the unit.
interface arith_count_unit_if
    import arith_count_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CNT_MOD = 10
);
    localparam int CW = $clog2(CNT_MOD);

    op_e              op;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic             tc;

    modport master (
        output op, in_valid, a, b, cin,
        input  sum, carry, ovf, out_valid, count, tc
    );

    modport slave (
        input  op, in_valid, a, b, cin,
        output sum, carry, ovf, out_valid, count, tc
    );

endinterface

// File: rtl/arith_count_unit_tick_gen.sv
// Prescaler: free-runs 0..DIV-1 while enabled, held at zero otherwise.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    // Combinational so that DIV=1 yields a tick on every enabled cycle.
    assign tick = en && !rst && (cnt == LAST);

endmodule

// File: rtl/arith_count_unit.sv
// Registered add/subtract datapath plus a prescaled modulo up/down counter.
module arith_count_unit
    import arith_count_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int CNT_MOD  = 10
) (
    input  logic               clk,
    input  logic               rst,
    arith_count_unit_if.slave  bus
);
    localparam int            CW       = $clog2(CNT_MOD);
    localparam int            TICK_DIV = tick_div(CLK_FREQ, TICK_HZ);
    localparam int            LW       = (WIDTH > 32) ? WIDTH : 32;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MOD - 1);

    // Result packing: {ovf, carry, sum}.
    function automatic logic [WIDTH+1:0] add_fn(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c);
        logic [WIDTH:0]          r;
        logic signed [WIDTH-1:0] sx, sy, sr;
        r  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        sx = signed'(x);
        sy = signed'(y);
        sr = signed'(r[WIDTH-1:0]);
        return {((sx < 0) == (sy < 0)) && ((sr < 0) != (sx < 0)), r};
    endfunction

    // Bit WIDTH of the extended difference is the unsigned borrow.
    function automatic logic [WIDTH+1:0] sub_fn(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c);
        logic [WIDTH:0]          r;
        logic signed [WIDTH-1:0] sx, sy, sr;
        r  = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
        sx = signed'(x);
        sy = signed'(y);
        sr = signed'(r[WIDTH-1:0]);
        return {((sx < 0) != (sy < 0)) && ((sr < 0) != (sx < 0)), r};
    endfunction

    function automatic logic [CW-1:0] sat_load(input logic [WIDTH-1:0] v);
        logic [LW-1:0] ext;
        ext = LW'(v);
        if (ext < LW'(CNT_MOD)) return CW'(v);
        else                    return CNT_LAST;
    endfunction

    op_e              op;
    logic             count_en;
    logic             tick;
    logic             arith_go;
    logic [WIDTH+1:0] arith_res;

    assign op        = bus.op;
    assign count_en  = (op == OP_CNT_UP) || (op == OP_CNT_DN);
    assign arith_go  = bus.in_valid && ((op == OP_ADD) || (op == OP_SUB));
    assign arith_res = (op == OP_SUB) ? sub_fn(bus.a, bus.b, bus.cin)
                                      : add_fn(bus.a, bus.b, bus.cin);

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (count_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum       <= '0;
            bus.carry     <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= arith_go;
            if (arith_go) begin
                {bus.ovf, bus.carry, bus.sum} <= arith_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.count <= '0;
            bus.tc    <= 1'b0;
        end else begin
            bus.tc <= 1'b0;
            case (op)
                OP_CNT_UP: if (tick) begin
                    if (bus.count == CNT_LAST) begin
                        bus.count <= '0;
                        bus.tc    <= 1'b1;
                    end else begin
                        bus.count <= bus.count + CW'(1);
                    end
                end
                OP_CNT_DN: if (tick) begin
                    if (bus.count == '0) begin
                        bus.count <= CNT_LAST;
                        bus.tc    <= 1'b1;
                    end else begin
                        bus.count <= bus.count - CW'(1);
                    end
                end
                OP_LOAD:  if (bus.in_valid) bus.count <= sat_load(bus.a);
                OP_CLEAR: if (bus.in_valid) bus.count <= '0;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_count_unit.sv
// Bench for arith_count_unit: vector table with scoreboard, then counter sequences.
module tb_arith_count_unit;
    import arith_count_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    arith_count_unit_if #(.WIDTH(4), .CNT_MOD(10)) bus ();

    arith_count_unit #(
        .WIDTH(4), .CLK_FREQ(4), .TICK_HZ(1), .CNT_MOD(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_e        op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [3:0] sum;
        logic       carry;
        logic       ovf;
    } res_t;

    vec_t vecs[10];
    res_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result();
        res_t r;
        chk("out_valid", int'(bus.out_valid), 1);
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                r = sb.pop_front();
                chk("sum",   int'(bus.sum),   int'(r.sum));
                chk("carry", int'(bus.carry), int'(r.carry));
                chk("ovf",   int'(bus.ovf),   int'(r.ovf));
            end
        end
    endtask

    task automatic run_count(input op_e o, input int n, input int exp_cnt, input int exp_tc);
        bus.op = o;
        for (int i = 0; i < n; i++) step();
        chk("count", int'(bus.count), exp_cnt);
        chk("tc",    int'(bus.tc),    exp_tc);
    endtask

    initial begin
        int tcs;
        vecs[0] = '{OP_ADD, 4'd7,  4'd9,  1'b1, 4'd1,  1'b1, 1'b0};
        vecs[1] = '{OP_ADD, 4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
        vecs[2] = '{OP_SUB, 4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0};
        vecs[3] = '{OP_SUB, 4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[4] = '{OP_ADD, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
        vecs[5] = '{OP_SUB, 4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
        vecs[6] = '{OP_ADD, 4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
        vecs[7] = '{OP_SUB, 4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0};
        vecs[8] = '{OP_SUB, 4'd7,  4'd15, 1'b1, 4'd7,  1'b1, 1'b0};
        vecs[9] = '{OP_ADD, 4'd4,  4'd3,  1'b1, 4'd8,  1'b0, 1'b1};

        bus.op = OP_PAUSE; bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        step(); step();
        chk("rst_sum",   int'(bus.sum), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_tc",    int'(bus.tc), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            bus.op = vecs[i].op; bus.a = vecs[i].a; bus.b = vecs[i].b;
            bus.cin = vecs[i].cin; bus.in_valid = 1'b1;
            sb.push_back('{vecs[i].sum, vecs[i].carry, vecs[i].ovf});
            step();
            check_result();
        end
        bus.in_valid = 1'b0; bus.a = 4'd1; bus.b = 4'd2;
        step();
        chk("idle_valid", int'(bus.out_valid), 0);
        chk("hold_sum",   int'(bus.sum), 8);
        chk("hold_carry", int'(bus.carry), 0);
        chk("hold_ovf",   int'(bus.ovf), 1);
        chk("sb_empty",   sb.size(), 0);
        chk("arith_count_untouched", int'(bus.count), 0);

        // 40 cycles of CNT_UP: one step per 4 cycles, single tc on 9->0.
        bus.op = OP_CNT_UP; bus.in_valid = 1'b1;
        tcs = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("up_count", int'(bus.count), (k / 4) % 10);
            chk("up_valid", int'(bus.out_valid), 0);
            tcs += int'(bus.tc);
        end
        chk("up_tc_last", int'(bus.tc), 1);
        chk("up_tc_total", tcs, 1);

        bus.op = OP_LOAD; bus.a = 4'd12; bus.in_valid = 1'b1;
        step();
        chk("load_sat", int'(bus.count), 9);
        chk("load_tc",  int'(bus.tc), 0);
        run_count(OP_CNT_DN, 3, 9, 0);
        run_count(OP_CNT_DN, 1, 8, 0);
        bus.op = OP_LOAD; bus.a = 4'd0;
        step();
        chk("load_zero", int'(bus.count), 0);
        run_count(OP_CNT_DN, 3, 0, 0);
        run_count(OP_CNT_DN, 1, 9, 1);
        step();
        chk("dn_tc_pulse_end", int'(bus.tc), 0);

        bus.op = OP_RSVD; bus.a = 4'd3;
        step();
        chk("rsvd_count", int'(bus.count), 9);
        chk("rsvd_valid", int'(bus.out_valid), 0);
        bus.op = OP_CLEAR;
        step();
        chk("clear_count", int'(bus.count), 0);

        run_count(OP_CNT_UP, 6, 1, 0);
        bus.op = OP_PAUSE;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("pause_count", int'(bus.count), 1);
        end
        run_count(OP_CNT_UP, 3, 1, 0);
        run_count(OP_CNT_UP, 1, 2, 0);

        run_count(OP_CNT_UP, 12, 5, 0);
        run_count(OP_CNT_UP, 2, 5, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_count", int'(bus.count), 0);
        chk("async_sum",   int'(bus.sum), 0);
        chk("async_carry", int'(bus.carry), 0);
        chk("async_ovf",   int'(bus.ovf), 0);
        chk("async_valid", int'(bus.out_valid), 0);
        chk("async_tc",    int'(bus.tc), 0);
        step();
        rst = 1'b0;
        run_count(OP_CNT_UP, 3, 0, 0);
        run_count(OP_CNT_UP, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
